// File: rtl/fp_add_issue_ctrl.sv
// Issue/retire controller in front of the pipelined FP adder: folds a-b into a+(-b),
// tracks in-flight ops with a valid/tag shift register and retires results in order
// through a credit-guarded first-word-fall-through FIFO.
module fp_add_issue_ctrl #(
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             pipe_areset,
   output logic             pipe_en,
   output logic [31:0]      pipe_a,
   output logic [31:0]      pipe_b,
   input  logic [31:0]      pipe_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_q,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic             run_q;
   logic [CNT_W-1:0] credits_q, credits_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [LATENCY:0] vld_sr_q, vld_sr_d;
   logic [TAG_W-1:0] tag_sr_q [LATENCY+1];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [31:0]      q_mem_q   [FIFO_DEPTH];
   logic [TAG_W-1:0] tag_mem_q [FIFO_DEPTH];

   logic issue;
   logic pop;
   logic push;

   assign pipe_areset = ~areset_n;
   assign pipe_en     = run_q;
   assign pipe_a      = in_a;
   assign pipe_b      = {in_b[31] ^ in_sub, in_b[30:0]};

   // run_q keeps in_ready low while reset is asserted even though credits reset to full.
   assign in_ready  = run_q & (credits_q != '0);
   assign out_valid = (count_q != '0);
   assign issue     = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign push      = vld_sr_q[LATENCY];

   assign out_q   = out_valid ? q_mem_q[rd_ptr_q]   : '0;
   assign out_tag = out_valid ? tag_mem_q[rd_ptr_q] : '0;
   assign busy    = (|vld_sr_q) | out_valid;

   assign vld_sr_d = {vld_sr_q[LATENCY-1:0], issue};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      credits_d = credits_q;
      count_d   = count_q;
      case ({issue, pop})
         2'b10:   credits_d = credits_q - ONE_C;
         2'b01:   credits_d = credits_q + ONE_C;
         default: credits_d = credits_q;
      endcase
      case ({push, pop})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         run_q     <= 1'b0;
         credits_q <= DEPTH_C;
         count_q   <= '0;
         vld_sr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         run_q     <= 1'b1;
         credits_q <= credits_d;
         count_q   <= count_d;
         vld_sr_q  <= vld_sr_d;
         wr_ptr_q  <= wr_ptr_q + PTR_W'(push);
         rd_ptr_q  <= rd_ptr_q + PTR_W'(pop);
      end
   end

   // NOTE: tag pipeline and result storage carry no reset; the valid bits and count qualify them.
   always_ff @(posedge clk) begin
      tag_sr_q[0] <= in_tag;
      for (int i = 1; i <= LATENCY; i++) begin
         tag_sr_q[i] <= tag_sr_q[i-1];
      end
      if (push) begin
         q_mem_q[wr_ptr_q]   <= pipe_q;
         tag_mem_q[wr_ptr_q] <= tag_sr_q[LATENCY];
      end
   end

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// Bench for fp_add_issue_ctrl: a behavioural adder drives pipe_q, and a queue model
// of outstanding ops predicts readiness, timing and in-order results every cycle.
module tb_fp_add_issue_ctrl;

   localparam int LATENCY    = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;

   logic             clk = 1'b0;
   logic             areset_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic             pipe_areset;
   logic             pipe_en;
   logic [31:0]      pipe_a;
   logic [31:0]      pipe_b;
   logic [31:0]      pipe_q;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_q;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   fp_add_issue_ctrl #(
      .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .areset_n(areset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_sub(in_sub), .in_tag(in_tag),
      .pipe_areset(pipe_areset), .pipe_en(pipe_en), .pipe_a(pipe_a), .pipe_b(pipe_b),
      .pipe_q(pipe_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_tag(out_tag),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Operands are restricted to multiples of 1/256 so plain integer arithmetic is exact.
   function automatic longint f32_to_fx(input logic [31:0] f);
      longint m, v;
      int     e;
      if (f[30:0] == 31'd0) return 0;
      m = longint'({1'b1, f[22:0]});
      e = int'(f[30:23]) - 127 - 23 + 8;
      v = (e >= 0) ? (m <<< e) : (m >>> (-e));
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] fx_to_f32(input longint v);
      longint      mag;
      int          p;
      logic [22:0] frac;
      logic        s;
      if (v == 0) return 32'h0;
      s   = (v < 0);
      mag = s ? -v : v;
      p   = 0;
      for (int i = 0; i < 63; i++) if (mag[i]) p = i;
      if (p >= 23) frac = 23'(mag >> (p - 23));
      else         frac = 23'(mag << (23 - p));
      return {s, 8'(p + 119), frac};
   endfunction

   // Behavioural adder: result visible LATENCY edges after the operands are sampled.
   logic [31:0] add_st [LATENCY+1];
   always @(posedge clk) begin
      if (pipe_en) begin
         add_st[0] <= fx_to_f32(f32_to_fx(pipe_a) + f32_to_fx(pipe_b));
         for (int i = 1; i <= LATENCY; i++) add_st[i] <= add_st[i-1];
      end
   end
   assign pipe_q = add_st[LATENCY];

   typedef struct {
      logic [31:0]      q;
      logic [TAG_W-1:0] tag;
      int               due;
   } exp_t;

   exp_t sb[$];
   bit   run;
   int   cyc;
   int   n_checks;
   int   n_errors;
   logic [TAG_W-1:0] next_tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: compare DUT outputs with the model, then advance the model across the edge.
   task automatic cycle();
      bit   exp_ov, fire_in, fire_out;
      exp_t e;
      #1;
      exp_ov = areset_n && (sb.size() > 0) && (sb[0].due <= cyc);
      check("pipe_en", pipe_en, run);
      check("pipe_areset", pipe_areset, !areset_n);
      check("in_ready", in_ready, run && (sb.size() < FIFO_DEPTH));
      check("busy", busy, sb.size() != 0);
      check("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
         check("out_q", out_q, sb[0].q);
         check("out_tag", out_tag, sb[0].tag);
      end
      if (!areset_n) begin
         check("out_q_rst", out_q, 0);
         check("out_tag_rst", out_tag, 0);
      end
      check("pipe_a", pipe_a, in_a);
      check("pipe_b", pipe_b, in_sub ? {~in_b[31], in_b[30:0]} : in_b);
      fire_in  = areset_n && in_valid && run && (sb.size() < FIFO_DEPTH);
      fire_out = exp_ov && out_ready;
      e.q   = fx_to_f32(in_sub ? f32_to_fx(in_a) - f32_to_fx(in_b)
                               : f32_to_fx(in_a) + f32_to_fx(in_b));
      e.tag = in_tag;
      @(posedge clk);
      cyc++;
      if (areset_n) begin
         if (fire_out) void'(sb.pop_front());
         if (fire_in) begin
            e.due = cyc + LATENCY + 1;
            sb.push_back(e);
         end
         run = 1'b1;
      end
      #1;
   endtask

   task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [TAG_W-1:0] tag);
      in_a = a; in_b = b; in_sub = sub; in_tag = tag;
   endtask

   task automatic rand_op();
      longint va, vb;
      va = longint'($urandom_range(0, 2**21)) - longint'(2**20);
      vb = longint'($urandom_range(0, 2**21)) - longint'(2**20);
      set_op(fx_to_f32(va), fx_to_f32(vb), 1'($urandom_range(0, 1)), next_tag);
      next_tag++;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      check("wait_valid_timeout", out_valid, 1);
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         cycle();
         n++;
      end
      check("drain_timeout", sb.size(), 0);
      cycle();
      check("busy_after_drain", busy, 0);
      out_ready = 1'b0;
   endtask

   task automatic fill_fifo();
      int accepts;
      accepts   = 0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      repeat (10) begin
         rand_op();
         if (in_ready) accepts++;
         cycle();
      end
      in_valid = 1'b0;
      check("fill_accepts", accepts, FIFO_DEPTH);
      check("fill_in_ready_low", in_ready, 0);
      check("fill_out_valid", out_valid, 1);
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_pipe_en", pipe_en, 0);
      check("rst_pipe_areset", pipe_areset, 1);
      check("rst_out_q", out_q, 0);
      check("rst_out_tag", out_tag, 0);
      sb.delete();
      run = 1'b0;
      repeat (2) cycle();
      areset_n = 1'b1;
      cycle();
   endtask

   initial begin
      int n;
      n_checks = 0; n_errors = 0; cyc = 0; run = 1'b0; next_tag = '0;
      areset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_op(32'h0, 32'h0, 1'b0, '0);
      do_reset();
      check("in_ready_after_release", in_ready, 1);

      // Single add: 1.0 + 4.125 = 5.125.
      set_op(32'h3F800000, 32'h40840000, 1'b0, 4'd1);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      wait_valid(n);
      check("single_latency", n, LATENCY + 1);
      check("single_q", out_q, 32'h40A40000);
      check("single_tag", out_tag, 4'd1);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      check("single_busy_after_pop", busy, 0);

      // Subtract: 127.75 - 27.75 = 100.
      set_op(32'h42FF8000, 32'h41DE0000, 1'b1, 4'd5);
      in_valid = 1'b1;
      #1;
      check("sub_pipe_b", pipe_b, 32'hC1DE0000);
      cycle();
      in_valid = 1'b0;
      wait_valid(n);
      check("sub_q", out_q, 32'h42C80000);
      drain();

      // Back-to-back with out_ready high.
      out_ready = 1'b1;
      set_op(32'h45000000, 32'h45000000, 1'b1, 4'd2);
      in_valid = 1'b1;
      check("b2b_ready0", in_ready, 1);
      cycle();
      set_op(32'h45000000, 32'h45000000, 1'b0, 4'd3);
      check("b2b_ready1", in_ready, 1);
      cycle();
      in_valid = 1'b0;
      wait_valid(n);
      check("b2b_q0", out_q, 32'h00000000);
      check("b2b_tag0", out_tag, 4'd2);
      cycle();
      check("b2b_valid1", out_valid, 1);
      check("b2b_q1", out_q, 32'h45800000);
      check("b2b_tag1", out_tag, 4'd3);
      drain();

      // Fill with out_ready low, then release: in_ready returns one cycle after the first pop.
      fill_fifo();
      out_ready = 1'b1;
      cycle();
      check("ready_after_first_pop", in_ready, 1);
      drain();

      // Full FIFO with in_valid and out_ready together.
      fill_fifo();
      rand_op();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check("full_no_accept", in_ready, 0);
      cycle();
      check("full_accept_next", in_ready, 1);
      rand_op();
      cycle();
      drain();

      // Reset with three ops in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (3) begin
         rand_op();
         cycle();
      end
      in_valid = 1'b0;
      check("inflight_busy", busy, 1);
      do_reset();
      repeat (8) cycle();
      check("no_stale_result", out_valid, 0);
      set_op(32'h3F800000, 32'h40840000, 1'b0, 4'd7);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      wait_valid(n);
      check("post_rst_latency", n, LATENCY + 1);
      check("post_rst_q", out_q, 32'h40A40000);
      check("post_rst_tag", out_tag, 4'd7);
      drain();
      fill_fifo();
      drain();

      // Randomised traffic with one reset in the middle.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         rand_op();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
